// File: rtl/uart_rx_param.sv
// uart_rx_param - parametrised UART receiver with an internal baud/oversample
// tick generator, 3-sample majority voting, parity and framing checks.
//
// Ports:
//   CLK        system clock, all logic on posedge
//   RST_N      synchronous active-low reset
//   RX         asynchronous serial line, idle high
//   data       last received word, LSB = first data bit
//   valid      one-cycle pulse when a frame completes (data and flags update with it)
//   parity_err parity mismatch on the last frame (always 0 when PARITY = 0)
//   frame_err  a stop bit of the last frame sampled low
//   busy       high from start detect until the FSM is back in IDLE
//
// State      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | line idle, counters held at 0, waiting for rx_s = 0
// START      | validating the start bit; majority 1 means false start
// DATA       | shifting in DATA_BITS bits LSB-first
// PAR        | checking the parity bit against the received data
// STOP       | sampling STOP_BITS stop bits, then presenting the frame
// WAIT_HIGH  | last stop bit was low (break); wait for the line to go high
module uart_rx_param #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int M   = OVERSAMPLE / 2;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);

  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [OW-1:0] OS_LAST  = OW'(OVERSAMPLE - 1);
  localparam logic [OW-1:0] OS_S0    = OW'(M - 1);
  localparam logic [OW-1:0] OS_S1    = OW'(M);
  localparam logic [OW-1:0] OS_DEC   = OW'(M + 1);
  localparam logic [BW-1:0] DB_LAST  = BW'(DATA_BITS - 1);
  localparam logic          SB_LAST  = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HIGH} state_t;

  state_t               state;
  logic                 rx_meta, rx_s;
  logic [PW-1:0]        pre_cnt;
  logic [OW-1:0]        os_cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic [1:0]           smp;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_flag, frm_flag, last_bit;

  logic tick, decide, wrap, maj, exp_par;

  assign tick    = (pre_cnt == PRE_LAST);
  assign decide  = tick && (os_cnt == OS_DEC);
  assign wrap    = tick && (os_cnt == OS_LAST);
  // third sample is the live rx_s at the decision tick
  assign maj     = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);
  assign exp_par = (^shreg) ^ (PARITY == 1);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= IDLE;
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      pre_cnt    <= '0;
      os_cnt     <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      smp        <= '0;
      shreg      <= '0;
      par_flag   <= 1'b0;
      frm_flag   <= 1'b0;
      last_bit   <= 1'b1;
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
      valid   <= 1'b0;

      // counters idle at 0 so the bit phase starts at the detected edge
      if (state == IDLE || state == WAIT_HIGH) begin
        pre_cnt <= '0;
        os_cnt  <= '0;
      end else if (tick) begin
        pre_cnt <= '0;
        os_cnt  <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end

      if (tick && os_cnt == OS_S0) smp[0] <= rx_s;
      if (tick && os_cnt == OS_S1) smp[1] <= rx_s;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            busy     <= 1'b1;
            par_flag <= 1'b0;
            frm_flag <= 1'b0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
          end
        end
        START: begin
          if (decide && maj) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (wrap) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (decide) shreg <= {maj, shreg[DATA_BITS-1:1]};
          if (wrap) begin
            if (bit_cnt == DB_LAST) begin
              bit_cnt <= '0;
              state   <= (PARITY != 0) ? PAR : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PAR: begin
          if (decide) par_flag <= maj ^ exp_par;
          if (wrap) state <= STOP;
        end
        STOP: begin
          // leave one cycle after the valid pulse so busy drops right after it
          if (valid) begin
            state <= last_bit ? IDLE : WAIT_HIGH;
            busy  <= !last_bit;
          end else if (decide) begin
            if (!maj) frm_flag <= 1'b1;
            if (stop_cnt == SB_LAST) begin
              valid      <= 1'b1;
              data       <= shreg;
              parity_err <= par_flag;
              frame_err  <= frm_flag | ~maj;
              last_bit   <= maj;
            end
          end else if (wrap) begin
            stop_cnt <= stop_cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
module tb_uart_rx_param;

  localparam int BIT = 432;

  logic clk = 1'b0;
  logic rst_n;
  logic rx_a, rx_b, rx_c;

  logic [7:0] data_a, data_b;
  logic [6:0] data_c;
  logic valid_a, valid_b, valid_c;
  logic perr_a, perr_b, perr_c;
  logic ferr_a, ferr_b, ferr_c;
  logic busy_a, busy_b, busy_c;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct packed {
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];
  int   tv_c[$];

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 8N1 defaults
  uart_rx_param dut_a (
    .CLK(clk), .RST_N(rst_n), .RX(rx_a), .data(data_a), .valid(valid_a),
    .parity_err(perr_a), .frame_err(ferr_a), .busy(busy_a)
  );

  // 8E1
  uart_rx_param #(.PARITY(2)) dut_b (
    .CLK(clk), .RST_N(rst_n), .RX(rx_b), .data(data_b), .valid(valid_b),
    .parity_err(perr_b), .frame_err(ferr_b), .busy(busy_b)
  );

  // 7O2
  uart_rx_param #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut_c (
    .CLK(clk), .RST_N(rst_n), .RX(rx_c), .data(data_c), .valid(valid_c),
    .parity_err(perr_c), .frame_err(ferr_c), .busy(busy_c)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s valid with empty scoreboard actual=1 expected=0", name);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid_a) begin
        if (q_a.size() == 0) unexpected("sb_a");
        else begin
          e = q_a.pop_front();
          check("sb_a_data", 32'(data_a), 32'(e.d));
          check("sb_a_perr", 32'(perr_a), 32'(e.pe));
          check("sb_a_ferr", 32'(ferr_a), 32'(e.fe));
        end
      end
      if (valid_b) begin
        if (q_b.size() == 0) unexpected("sb_b");
        else begin
          e = q_b.pop_front();
          check("sb_b_data", 32'(data_b), 32'(e.d));
          check("sb_b_perr", 32'(perr_b), 32'(e.pe));
          check("sb_b_ferr", 32'(ferr_b), 32'(e.fe));
        end
      end
      if (valid_c) begin
        tv_c.push_back(cyc);
        if (q_c.size() == 0) unexpected("sb_c");
        else begin
          e = q_c.pop_front();
          check("sb_c_data", 32'(data_c), 32'(e.d));
          check("sb_c_perr", 32'(perr_c), 32'(e.pe));
          check("sb_c_ferr", 32'(ferr_c), 32'(e.fe));
        end
      end
    end
  endtask

  task automatic drive_bit(input int w, input logic b);
    case (w)
      0: rx_a = b;
      1: rx_b = b;
      default: rx_c = b;
    endcase
    repeat (BIT) @(negedge clk);
  endtask

  // pb < 0 means no parity bit; every stop bit takes value sv
  task automatic send_frame(input int w, input logic [8:0] d, input int nb,
                            input int pb, input int ns, input logic sv);
    drive_bit(w, 1'b0);
    for (int i = 0; i < nb; i++) drive_bit(w, d[i]);
    if (pb >= 0) drive_bit(w, pb[0]);
    for (int i = 0; i < ns; i++) drive_bit(w, sv);
  endtask

  task automatic wait_valid_a_then_busy();
    int k;
    k = 0;
    while (!valid_a && k < 6000) begin
      @(negedge clk);
      k++;
    end
    if (!valid_a) begin
      checks++;
      errors++;
      $display("FAIL a5_valid_timeout actual=0 expected=1");
    end else begin
      @(negedge clk);
      check("a5_busy_after_valid", 32'(busy_a), 32'h0);
    end
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    rx_a = 1'b1;
    rx_b = 1'b1;
    rx_c = 1'b1;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    check("rst_data", 32'(data_a), 32'h0);
    check("rst_valid", 32'(valid_a), 32'h0);
    check("rst_perr", 32'(perr_a), 32'h0);
    check("rst_ferr", 32'(ferr_a), 32'h0);
    check("rst_busy", 32'(busy_a), 32'h0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // 8N1 0xA5
    q_a.push_back('{d: 9'h0A5, pe: 1'b0, fe: 1'b0});
    fork
      send_frame(0, 9'h0A5, 8, -1, 1, 1'b1);
      wait_valid_a_then_busy();
    join
    repeat (20) @(negedge clk);

    // 0x00 with a 1-CLK high glitch on the centre sample of data bit 2
    q_a.push_back('{d: 9'h000, pe: 1'b0, fe: 1'b0});
    rx_a = 1'b0;
    repeat (1539) @(negedge clk);
    rx_a = 1'b1;
    @(negedge clk);
    rx_a = 1'b0;
    repeat (3888 - 1540) @(negedge clk);
    drive_bit(0, 1'b1);
    repeat (20) @(negedge clk);

    // break: stop bit low, line held low 3 more bit periods
    q_a.push_back('{d: 9'h000, pe: 1'b0, fe: 1'b1});
    send_frame(0, 9'h000, 8, -1, 1, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(0, 1'b0);
    check("brk_busy_held", 32'(busy_a), 32'h1);
    rx_a = 1'b1;
    repeat (5) @(negedge clk);
    check("brk_busy_release", 32'(busy_a), 32'h0);
    repeat (20) @(negedge clk);
    q_a.push_back('{d: 9'h05A, pe: 1'b0, fe: 1'b0});
    send_frame(0, 9'h05A, 8, -1, 1, 1'b1);
    repeat (20) @(negedge clk);

    // false start: 100 CLK low pulse
    rx_a = 1'b0;
    repeat (50) @(negedge clk);
    check("fs_busy_high", 32'(busy_a), 32'h1);
    repeat (50) @(negedge clk);
    rx_a = 1'b1;
    repeat (BIT) @(negedge clk);
    check("fs_busy_low", 32'(busy_a), 32'h0);
    check("fs_data_kept", 32'(data_a), 32'h5A);

    // reset pulse during data bit 3 of a 0x00 frame
    rx_a = 1'b0;
    repeat (1900) @(negedge clk);
    rst_n = 1'b0;
    rx_a = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_data", 32'(data_a), 32'h0);
    check("mid_rst_valid", 32'(valid_a), 32'h0);
    check("mid_rst_perr", 32'(perr_a), 32'h0);
    check("mid_rst_ferr", 32'(ferr_a), 32'h0);
    check("mid_rst_busy", 32'(busy_a), 32'h0);
    repeat (2 * BIT) @(negedge clk);
    q_a.push_back('{d: 9'h03C, pe: 1'b0, fe: 1'b0});
    send_frame(0, 9'h03C, 8, -1, 1, 1'b1);
    repeat (20) @(negedge clk);

    // 8E1: 0x07 needs parity 1, send 0; 0x03 needs 0, send 0
    q_b.push_back('{d: 9'h007, pe: 1'b1, fe: 1'b0});
    send_frame(1, 9'h007, 8, 0, 1, 1'b1);
    q_b.push_back('{d: 9'h003, pe: 1'b0, fe: 1'b0});
    send_frame(1, 9'h003, 8, 0, 1, 1'b1);
    repeat (20) @(negedge clk);

    // 7O2 back-to-back: 0x55 (odd parity 1), 0x2A (odd parity 0)
    q_c.push_back('{d: 9'h055, pe: 1'b0, fe: 1'b0});
    q_c.push_back('{d: 9'h02A, pe: 1'b0, fe: 1'b0});
    send_frame(2, 9'h055, 7, 1, 2, 1'b1);
    send_frame(2, 9'h02A, 7, 0, 2, 1'b1);

    k = 0;
    while ((q_a.size() + q_b.size() + q_c.size()) != 0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    repeat (20) @(negedge clk);
    check("drain_a", 32'(q_a.size()), 32'h0);
    check("drain_b", 32'(q_b.size()), 32'h0);
    check("drain_c", 32'(q_c.size()), 32'h0);
    check("c_valid_count", 32'(tv_c.size()), 32'd2);
    if (tv_c.size() >= 2) check("c_valid_spacing", 32'(tv_c[1] - tv_c[0]), 32'(11 * BIT));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
